// File: rtl/rej_uniform_sampler.sv
// Rejection sampler: turns the SHAKE128 squeeze stream into uniform coefficients in [0, Q).
// Optional feature macro REJ_SAMPLER_STATS_EN adds a saturating rej_count output.
module rej_uniform_sampler #(
  parameter int DATA_IN_BITS = 512,
  parameter int Q            = 8380417,
  parameter int N_COEF       = 256,
  parameter int COEF_W       = 23,
  parameter int SAMPLE_W     = 24
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [DATA_IN_BITS-1:0]         data_in,
  input  logic                            in_valid,
  input  logic                            in_last,
  input  logic [$clog2(DATA_IN_BITS)-1:0] in_last_len,
  output logic                            in_ready,
  output logic [COEF_W-1:0]               coef_out,
  output logic [7:0]                      coef_idx,
  output logic                            coef_valid,
  input  logic                            coef_ready,
  output logic                            done
`ifdef REJ_SAMPLER_STATS_EN
  ,
  output logic [15:0]                     rej_count
`endif
);

  localparam int BUF_W = DATA_IN_BITS + SAMPLE_W - 1;
  localparam int CNT_W = $clog2(BUF_W + 1);
  localparam int IDX_W = $clog2(N_COEF + 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t             state, state_nxt;
  logic [BUF_W-1:0]   buf_p0;
  logic [CNT_W-1:0]   cnt_p0;
  logic [IDX_W-1:0]   acc_cnt;
  logic [COEF_W-1:0]  coef_p1;
  logic [7:0]         idx_p1;
  logic               vld_p1;

  logic [CNT_W-1:0]   word_len;
  logic [BUF_W-1:0]   len_mask;
  logic [COEF_W-1:0]  cand;
  logic               cand_ok;
  logic               load;
  logic               step;
  logic               last_coef;

  function automatic logic is_accept(input logic [COEF_W-1:0] c);
    return c < COEF_W'(Q);
  endfunction

`ifdef REJ_SAMPLER_STATS_EN
  logic [15:0] rej_cnt;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign rej_count = rej_cnt;
`endif

  // Stage p0: bit buffer, candidate extraction and accept decision
  always_comb begin
    word_len = CNT_W'(DATA_IN_BITS);
    if (in_last && (in_last_len != '0))
      word_len = CNT_W'(in_last_len);
  end

  // Bits above the valid length are masked so a short word can never corrupt residual bits.
  assign len_mask  = (BUF_W'(1) << word_len) - BUF_W'(1);
  assign cand      = buf_p0[COEF_W-1:0];
  assign cand_ok   = is_accept(cand);
  assign in_ready  = (state == RUN) && (cnt_p0 < CNT_W'(SAMPLE_W)) && !start;
  assign load      = in_valid && in_ready;
  assign step      = (state == RUN) && (cnt_p0 >= CNT_W'(SAMPLE_W)) && (!vld_p1 || coef_ready);
  assign last_coef = (acc_cnt == IDX_W'(N_COEF - 1));
  assign done      = (state == FLUSH) && vld_p1 && coef_ready && !start;

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = RUN;
    end else begin
      case (state)
        RUN:     if (step && cand_ok && last_coef) state_nxt = FLUSH;
        FLUSH:   if (vld_p1 && coef_ready)          state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      buf_p0  <= '0;
      cnt_p0  <= '0;
      acc_cnt <= '0;
    end else if (load) begin
      buf_p0 <= buf_p0 | ((BUF_W'(data_in) & len_mask) << cnt_p0);
      cnt_p0 <= cnt_p0 + word_len;
    end else if (step) begin
      buf_p0 <= buf_p0 >> SAMPLE_W;
      cnt_p0 <= cnt_p0 - CNT_W'(SAMPLE_W);
      if (cand_ok)
        acc_cnt <= acc_cnt + IDX_W'(1);
    end
  end

  // Stage p1: output register holding the accepted coefficient
  always_ff @(posedge clk) begin
    if (rst) begin
      coef_p1 <= '0;
      idx_p1  <= '0;
      vld_p1  <= 1'b0;
    end else if (start) begin
      idx_p1  <= '0;
      vld_p1  <= 1'b0;
    end else if (step && cand_ok) begin
      coef_p1 <= cand;
      idx_p1  <= 8'(acc_cnt);
      vld_p1  <= 1'b1;
    end else if (vld_p1 && coef_ready) begin
      vld_p1  <= 1'b0;
    end
  end

`ifdef REJ_SAMPLER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || start)
      rej_cnt <= '0;
    else if (step && !cand_ok)
      rej_cnt <= sat_inc16(rej_cnt);
  end
`endif

  assign coef_out   = coef_p1;
  assign coef_idx   = idx_p1;
  assign coef_valid = vld_p1;

endmodule

// File: tb/tb_rej_uniform_sampler.sv
// Directed bench for rej_uniform_sampler: hand-computed vectors plus a bit-stream reference model.
module tb_rej_uniform_sampler;

  localparam int DW = 512;
  localparam int QV = 8380417;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [8:0]    in_last_len = '0;
  logic          in_ready;
  logic [22:0]   coef_out;
  logic [7:0]    coef_idx;
  logic          coef_valid;
  logic          coef_ready = 1'b0;
  logic          done;
`ifdef REJ_SAMPLER_STATS_EN
  logic [15:0]   rej_count;
`endif

  rej_uniform_sampler dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .data_in     (data_in),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_last_len (in_last_len),
    .in_ready    (in_ready),
    .coef_out    (coef_out),
    .coef_idx    (coef_idx),
    .coef_valid  (coef_valid),
    .coef_ready  (coef_ready),
    .done        (done)
`ifdef REJ_SAMPLER_STATS_EN
    ,
    .rej_count   (rej_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] words [0:15];
  logic          lasts [0:15];
  logic [8:0]    lens  [0:15];
  bit            sbits [0:16383];
  logic [22:0]   exp_val [0:299];
  logic [22:0]   got_val [0:299];
  logic [7:0]    got_idx [0:299];
  int nexp, nrej_exp, ngot, ndone, wp, nbad_stall;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_words();
    for (int i = 0; i < 16; i++) begin
      words[i] = '0;
      lasts[i] = 1'b0;
      lens[i]  = '0;
    end
  endtask

  task automatic rand_words(input int n);
    for (int i = 0; i < n; i++)
      for (int k = 0; k < DW / 32; k++)
        words[i][32*k +: 32] = $urandom;
  endtask

  // Reference: flatten the words into one bit stream, then walk 24-bit candidates.
  task automatic build_exp(input int n_words);
    int pos, len;
    logic [22:0] v;
    pos = 0;
    for (int w = 0; w < n_words; w++) begin
      len = DW;
      if (lasts[w] && lens[w] != 0) len = int'(lens[w]);
      for (int b = 0; b < len; b++) begin
        sbits[pos] = words[w][b];
        pos++;
      end
    end
    nexp = 0;
    nrej_exp = 0;
    for (int p = 0; p + 24 <= pos && nexp < 256; p += 24) begin
      for (int b = 0; b < 23; b++) v[b] = sbits[p + b];
      if (int'(v) < QV) begin
        exp_val[nexp] = v;
        nexp++;
      end else begin
        nrej_exp++;
      end
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    in_valid = 1'b0;
    coef_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input int n_words, input int stop_at, input int max_cyc, input int stall_at);
    logic [22:0] hv;
    logic [7:0]  hi;
    hv = '0;
    hi = '0;
    wp = 0;
    ngot = 0;
    ndone = 0;
    nbad_stall = 0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      in_valid = (wp < n_words);
      if (wp < n_words) begin
        data_in     = words[wp];
        in_last     = lasts[wp];
        in_last_len = lens[wp];
      end
      coef_ready = !(stall_at >= 0 && c >= stall_at && c < stall_at + 10);
      #1;
      if (stall_at >= 0 && c == stall_at + 3) begin
        check_eq("stall_vld", 32'(coef_valid), 32'd1);
        hv = coef_out;
        hi = coef_idx;
      end
      if (stall_at >= 0 && c > stall_at + 3 && c < stall_at + 10)
        if (coef_out !== hv || coef_idx !== hi || coef_valid !== 1'b1) nbad_stall++;
      if (in_valid && in_ready) wp++;
      if (coef_valid && coef_ready) begin
        got_val[ngot] = coef_out;
        got_idx[ngot] = coef_idx;
        ngot++;
      end
      if (done) ndone++;
      if (ndone > 0) begin
        in_valid = 1'b0;
        break;
      end
      if (ngot >= stop_at) begin
        in_valid = 1'b0;
        coef_ready = 1'b0;
        break;
      end
    end
    if (stall_at >= 0) check_eq("stall_hold", 32'(nbad_stall), 32'd0);
  endtask

  task automatic cmp_stream(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < ngot; i++)
      if (i >= nexp || got_val[i] !== exp_val[i] || got_idx[i] !== 8'(i)) bad++;
    check_eq({tag, "_stream"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int nacc, nd;
    clear_words();
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_coef_valid", 32'(coef_valid), 32'd0);
    check_eq("rst_coef_out", 32'(coef_out), 32'd0);
    check_eq("rst_coef_idx", 32'(coef_idx), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    rst = 1'b0;

    // All-zero stream: 256 zeros from exactly 12 words, single done
    clear_words();
    build_exp(14);
    do_start();
    run(14, 1000, 400, -1);
    check_eq("t1_ngot", 32'(ngot), 32'd256);
    check_eq("t1_done", 32'(ndone), 32'd1);
    check_eq("t1_words", 32'(wp), 32'd12);
    check_eq("t1_last_idx", 32'(got_idx[255]), 32'd255);
    cmp_stream("t1");
    nacc = 0;
    nd = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      #1;
      if (in_ready) nacc++;
      if (done) nd++;
    end
    in_valid = 1'b0;
    check_eq("t1_no_ready_after", 32'(nacc), 32'd0);
    check_eq("t1_no_done_after", 32'(nd), 32'd0);
    check_eq("t1_vld_after", 32'(coef_valid), 32'd0);

    // Rejection boundary: 0x7FE001 rejected, 0x7FE000 accepted, 0xFFE000 masked
    clear_words();
    words[0] = {440'h0, 24'hFFE000, 24'h7FE000, 24'h7FE001};
    build_exp(1);
    do_start();
    run(1, 1000, 40, -1);
    check_eq("t2_ngot", 32'(ngot), 32'd20);
    check_eq("t2_c0", 32'(got_val[0]), 32'd8380416);
    check_eq("t2_i0", 32'(got_idx[0]), 32'd0);
    check_eq("t2_c1", 32'(got_val[1]), 32'h7FE000);
    check_eq("t2_i1", 32'(got_idx[1]), 32'd1);
    check_eq("t2_c2", 32'(got_val[2]), 32'd0);
    cmp_stream("t2");
`ifdef REJ_SAMPLER_STATS_EN
    check_eq("t2_rej_count", 32'(rej_count), 32'd1);
`endif

    // Candidate straddling two words
    clear_words();
    words[0] = {8'hC3, 504'h0};
    words[1] = {496'h0, 16'h9F12};
    build_exp(2);
    do_start();
    run(2, 1000, 80, -1);
    check_eq("t3_ngot", 32'(ngot), 32'd42);
    check_eq("t3_c20", 32'(got_val[20]), 32'd0);
    check_eq("t3_c21", 32'(got_val[21]), 32'h1F12C3);
    check_eq("t3_i21", 32'(got_idx[21]), 32'd21);
    cmp_stream("t3");

    // Short last word of 320 bits: 8 residual bits join the next word
    clear_words();
    words[0] = {192'h0, 8'h5A, 312'h0};
    lasts[0] = 1'b1;
    lens[0]  = 9'd320;
    words[1] = {496'h0, 16'h3C71};
    build_exp(2);
    do_start();
    run(2, 1000, 80, -1);
    check_eq("t4_ngot", 32'(ngot), 32'd34);
    check_eq("t4_c12", 32'(got_val[12]), 32'd0);
    check_eq("t4_c13", 32'(got_val[13]), 32'h3C715A);
    cmp_stream("t4");

    // Random stream with a 10-cycle consumer stall
    clear_words();
    rand_words(14);
    build_exp(14);
    do_start();
    run(14, 1000, 500, 30);
    check_eq("t5_ngot", 32'(ngot), 32'd256);
    check_eq("t5_done", 32'(ndone), 32'd1);
    cmp_stream("t5");
`ifdef REJ_SAMPLER_STATS_EN
    check_eq("t5_rej_count", 32'(rej_count), 32'(nrej_exp));
`endif

    // Restart after 100 coefficients, then reset in RUN
    clear_words();
    rand_words(14);
    build_exp(14);
    do_start();
    run(14, 100, 300, -1);
    check_eq("t6a_ngot", 32'(ngot), 32'd100);
    cmp_stream("t6a");
    clear_words();
    rand_words(14);
    build_exp(14);
    do_start();
    run(14, 30, 100, -1);
    check_eq("t6b_ngot", 32'(ngot), 32'd30);
    check_eq("t6b_i0", 32'(got_idx[0]), 32'd0);
    cmp_stream("t6b");
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    coef_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("t6_rst_coef_valid", 32'(coef_valid), 32'd0);
    check_eq("t6_rst_coef_out", 32'(coef_out), 32'd0);
    check_eq("t6_rst_coef_idx", 32'(coef_idx), 32'd0);
    check_eq("t6_rst_done", 32'(done), 32'd0);
    nacc = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      coef_ready = 1'b1;
      #1;
      if (in_ready) nacc++;
    end
    in_valid = 1'b0;
    check_eq("t6_no_ready_after_rst", 32'(nacc), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
